// File: rtl/decode_queue_stage_if.sv
// Handshake bundle between fetch, the decode queue and execute.
// Fetch side: in_valid/in_ready with instr_in/pc_in. Execute side: out_valid/out_ready
// with the decoded head entry (pc_out, fields, imm, imm_fmt, illegal) and occupancy.
interface decode_queue_stage_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              instr_in;
  logic [XLEN-1:0]          pc_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          pc_out;
  logic [6:0]               opcode;
  logic [4:0]               rd;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [XLEN-1:0]          imm;
  logic [2:0]               imm_fmt;
  logic                     illegal;
  logic [$clog2(DEPTH):0]   occupancy;

  // The queue itself.
  modport slave (
    input  in_valid, instr_in, pc_in, out_ready,
    output in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
           funct3, funct7, imm, imm_fmt, illegal, occupancy
  );

  // Fetch/execute environment around the queue.
  modport master (
    output in_valid, instr_in, pc_in, out_ready,
    input  in_ready, out_valid, pc_out, opcode, rd, rs1, rs2,
           funct3, funct7, imm, imm_fmt, illegal, occupancy
  );
endinterface

// File: rtl/decode_queue_stage.sv
// Purpose: DEPTH-entry instruction FIFO between fetch and execute; decodes the head entry.
// Latency: an instruction accepted at edge N is presented (out_valid=1) in cycle N+1.
// Backpressure: in_ready = count < DEPTH from registered state only; flush empties the queue.
// Ports: clk, nrst (async active-low), flush, bus (slave modport: fetch in / decoded head out).
module decode_queue_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 flush,
  decode_queue_stage_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  logic [31:0]     r_instr [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic               w_in_ready;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_instr;
  logic [6:0]         w_op;
  logic [2:0]         w_fmt;
  logic               w_illegal;
  logic signed [31:0] w_imm32;

  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign w_push     = bus.in_valid && w_in_ready && !flush;
  assign w_pop      = w_valid && bus.out_ready && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Entry storage needs no reset: nothing is read unless count says it was written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= bus.instr_in;
      r_pc[r_wr_ptr]    <= bus.pc_in;
    end
  end

  assign w_instr = r_instr[r_rd_ptr];
  assign w_op    = w_instr[6:0];

  always_comb begin
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    case (w_op)
      7'b0000011, 7'b0010011, 7'b1100111: w_fmt = FMT_I;
      7'b0011011: begin
        if (XLEN == 64) w_fmt = FMT_I;
        else            w_illegal = 1'b1;
      end
      7'b0100011: w_fmt = FMT_S;
      7'b1100011: w_fmt = FMT_B;
      7'b0110111, 7'b0010111: w_fmt = FMT_U;
      7'b1101111: w_fmt = FMT_J;
      7'b0110011, 7'b0001111, 7'b1110011: w_fmt = FMT_NONE;
      7'b0111011: begin
        if (XLEN != 64) w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    // Every listed opcode already ends in 2'b11; kept explicit so the
    // compressed-encoding rule survives future opcode-table edits.
    if (w_instr[1:0] != 2'b11) w_illegal = 1'b1;
    if (w_illegal) w_fmt = FMT_NONE;
  end

  always_comb begin
    w_imm32 = '0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      FMT_S:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      FMT_B:   w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                          w_instr[30:25], w_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {w_instr[31:12], 12'h000};
      FMT_J:   w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                          w_instr[20], w_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // All head-derived outputs read as zero while the queue is empty.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.occupancy = r_count;
  assign bus.pc_out    = w_valid ? r_pc[r_rd_ptr]    : '0;
  assign bus.opcode    = w_valid ? w_op              : '0;
  assign bus.rd        = w_valid ? w_instr[11:7]     : '0;
  assign bus.rs1       = w_valid ? w_instr[19:15]    : '0;
  assign bus.rs2       = w_valid ? w_instr[24:20]    : '0;
  assign bus.funct3    = w_valid ? w_instr[14:12]    : '0;
  assign bus.funct7    = w_valid ? w_instr[31:25]    : '0;
  assign bus.imm       = w_valid ? XLEN'(w_imm32)    : '0;
  assign bus.imm_fmt   = w_valid ? w_fmt             : '0;
  assign bus.illegal   = w_valid ? w_illegal         : 1'b0;
endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench: drives one shared stimulus stream into an XLEN=32 and an XLEN=64 instance,
// compares both every cycle against a queue-based reference, plus literal spot checks.
module tb_decode_queue_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr_in;
  logic [63:0] pc_in;
  logic        out_ready;
  logic        run = 1'b0;
  logic        acc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_queue_stage_if #(.XLEN(32), .DEPTH(DEPTH)) if32 ();
  decode_queue_stage_if #(.XLEN(64), .DEPTH(DEPTH)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.instr_in  = instr_in;
  assign if32.pc_in     = pc_in[31:0];
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.instr_in  = instr_in;
  assign if64.pc_in     = pc_in;
  assign if64.out_ready = out_ready;

  decode_queue_stage #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .nrst(nrst), .flush(flush), .bus(if32));
  decode_queue_stage #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .nrst(nrst), .flush(flush), .bus(if64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the format table and immediate bit layouts.
  function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                  output int fmt, output longint imm, output bit ill);
    logic [6:0] op;
    op = ins[6:0];
    fmt = 0; imm = 0; ill = 1'b0;
    if (ins[1:0] != 2'b11) ill = 1'b1;
    else if (op == 7'h03 || op == 7'h13 || op == 7'h67 || (x64 && op == 7'h1B)) fmt = 1;
    else if (op == 7'h23) fmt = 2;
    else if (op == 7'h63) fmt = 3;
    else if (op == 7'h37 || op == 7'h17) fmt = 4;
    else if (op == 7'h6F) fmt = 5;
    else if (!(op == 7'h33 || op == 7'h0F || op == 7'h73 || (x64 && op == 7'h3B))) ill = 1'b1;
    case (fmt)
      1: imm = longint'($signed(ins[31:20]));
      2: imm = longint'($signed({ins[31:25], ins[11:7]}));
      3: imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      4: imm = longint'($signed({ins[31:12], 12'h000}));
      5: imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: imm = 0;
    endcase
  endfunction

  typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;
  ent_t q[$];

  // Reference queue: plain push/pop on a SystemVerilog queue.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) q.delete();
    else begin
      bit do_push, do_pop;
      do_push = in_valid && (q.size() < DEPTH) && !flush;
      do_pop  = (q.size() != 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{instr: instr_in, pc: pc_in});
      end
    end
  end

  task automatic cmp_dut(input string tag, input bit x64,
      input logic ov, input logic ir, input logic [7:0] occ, input logic [63:0] pco,
      input logic [6:0] op, input logic [4:0] rd_, input logic [4:0] rs1_,
      input logic [4:0] rs2_, input logic [2:0] f3, input logic [6:0] f7,
      input logic [63:0] im, input logic [2:0] fm, input logic il);
    int n;
    logic [31:0] ins;
    logic [63:0] pce, ime;
    int ef;
    longint li;
    bit eil;
    n = q.size(); ins = '0; pce = '0; ime = '0; ef = 0; eil = 1'b0;
    if (n > 0) begin
      ins = q[0].instr;
      pce = q[0].pc;
      ref_dec(ins, x64, ef, li, eil);
      ime = li;
      if (!x64) begin
        pce = {32'h0, pce[31:0]};
        ime = {32'h0, ime[31:0]};
      end
    end
    chk({tag, " out_valid"}, ov, n != 0);
    chk({tag, " in_ready"}, ir, n < DEPTH);
    chk({tag, " occupancy"}, occ, n);
    chk({tag, " pc_out"}, pco, pce);
    chk({tag, " opcode"}, op, ins[6:0]);
    chk({tag, " rd"}, rd_, ins[11:7]);
    chk({tag, " rs1"}, rs1_, ins[19:15]);
    chk({tag, " rs2"}, rs2_, ins[24:20]);
    chk({tag, " funct3"}, f3, ins[14:12]);
    chk({tag, " funct7"}, f7, ins[31:25]);
    chk({tag, " imm"}, im, ime);
    chk({tag, " imm_fmt"}, fm, ef);
    chk({tag, " illegal"}, il, eil);
  endtask

  always @(negedge clk) begin
    if (nrst && run) begin
      cmp_dut("x32", 1'b0, if32.out_valid, if32.in_ready, 8'(if32.occupancy),
              {32'h0, if32.pc_out}, if32.opcode, if32.rd, if32.rs1, if32.rs2,
              if32.funct3, if32.funct7, {32'h0, if32.imm}, if32.imm_fmt, if32.illegal);
      cmp_dut("x64", 1'b1, if64.out_valid, if64.in_ready, 8'(if64.occupancy),
              if64.pc_out, if64.opcode, if64.rd, if64.rs1, if64.rs2,
              if64.funct3, if64.funct7, if64.imm, if64.imm_fmt, if64.illegal);
    end
  end

  // acc records whether the offer standing before the coming edge is taken.
  task automatic tick();
    @(negedge clk);
    acc = in_valid && if32.in_ready && !flush;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                     input logic ordy, input logic fl);
    in_valid = v; instr_in = ins; pc_in = pc; out_ready = ordy; flush = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] f_ins [4] = '{32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'hFFDFF0EF};
  logic [2:0]  f_fmt [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
  logic [63:0] f_imm [4] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
                             64'h0000_0000_1234_5000, 64'hFFFF_FFFF_FFFF_FFFC};

  initial begin
    int fm, accepted;
    longint im;
    bit il;

    // Pin the reference decoder with hand-computed values.
    for (int i = 0; i < 4; i++) begin
      ref_dec(f_ins[i], 1'b1, fm, im, il);
      chk("model fmt", fm, f_fmt[i]);
      chk("model imm", im, f_imm[i]);
    end
    ref_dec(32'h0000001B, 1'b0, fm, im, il);
    chk("model illegal 1B x32", il, 1'b1);

    nrst = 1'b0;
    drv(0, 0, 0, 0, 0);
    #12;
    chk("reset out_valid", if32.out_valid, 0);
    chk("reset in_ready", if32.in_ready, 1);
    chk("reset occupancy", if32.occupancy, 0);
    chk("reset pc_out", if64.pc_out, 0);
    chk("reset imm", if64.imm, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    run  = 1'b1;

    // addi x1,x0,-1 at pc 0x100
    drv(1, 32'hFFF00093, 64'h100, 1, 0);
    tick();
    drv(0, 0, 0, 1, 0);
    chk("addi out_valid", if32.out_valid, 1);
    chk("addi rd", if32.rd, 1);
    chk("addi rs1", if32.rs1, 0);
    chk("addi imm_fmt", if32.imm_fmt, 1);
    chk("addi imm x32", if32.imm, 32'hFFFF_FFFF);
    chk("addi imm x64", if64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi pc_out", if32.pc_out, 32'h100);
    chk("addi illegal", if32.illegal, 0);
    tick();

    // Per-format immediates, streamed back-to-back.
    for (int i = 0; i < 4; i++) begin
      drv(1, f_ins[i], 64'h200 + 64'(4 * i), 1, 0);
      tick();
      chk("fmt x32 imm_fmt", if32.imm_fmt, f_fmt[i]);
      chk("fmt x32 imm", if32.imm, f_imm[i][31:0]);
      chk("fmt x64 imm", if64.imm, f_imm[i]);
    end
    drv(0, 0, 0, 1, 0);
    tick();
    chk("fmt drained", if32.occupancy, 0);

    // Fill with out_ready low: only DEPTH of DEPTH+1 offers are taken.
    accepted = 0;
    drv(1, 32'h00000013, 64'h1000, 0, 0);
    for (int c = 0; c < 3 * DEPTH; c++) begin
      tick();
      if (acc) begin
        accepted++;
        if (accepted <= DEPTH)
          drv(1, 32'h00000013 | (32'(accepted) << 7), 64'h1000 + 64'(4 * accepted), 0, 0);
      end
    end
    chk("fill accepts", accepted, DEPTH);
    chk("full in_ready", if32.in_ready, 0);
    chk("full occupancy", if64.occupancy, DEPTH);
    out_ready = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        tick();
        got = acc;
      end
      chk("extra entry accepted", got, 1);
    end
    in_valid = 1'b0;
    repeat (DEPTH + 2) tick();
    chk("drain occupancy", if32.occupancy, 0);

    // Flush with two entries held and an offer in the flush cycle.
    drv(1, 32'h00100093, 64'h3000, 0, 0);
    tick();
    drv(1, 32'h00200093, 64'h3004, 0, 0);
    tick();
    chk("preflush occupancy", if32.occupancy, 2);
    drv(1, 32'hDEAD0093, 64'h3008, 0, 1);
    tick();
    drv(0, 0, 0, 1, 0);
    chk("flush out_valid", if32.out_valid, 0);
    chk("flush occupancy", if64.occupancy, 0);
    chk("flush in_ready", if32.in_ready, 1);
    repeat (3) tick();

    // Illegal encodings still flow through.
    drv(1, 32'h00000000, 64'h4000, 1, 0);
    tick();
    chk("ill0 illegal", if32.illegal, 1);
    chk("ill0 imm", if32.imm, 0);
    chk("ill0 fmt", if32.imm_fmt, 0);
    drv(1, 32'h0000001B, 64'h4004, 1, 0);
    tick();
    chk("ill1B x32 illegal", if32.illegal, 1);
    chk("ill1B x32 imm", if32.imm, 0);
    chk("ill1B x64 legal", if64.illegal, 0);
    chk("ill1B x64 fmt", if64.imm_fmt, 1);
    drv(0, 0, 0, 1, 0);
    tick();
    chk("illegal popped", if32.occupancy, 0);

    // Randomized traffic; the compare process checks every cycle.
    acc = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        logic [31:0] ins;
        logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h3B};
        ins = $urandom;
        if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 11)];
        in_valid = ($urandom_range(0, 3) != 0);
        instr_in = ins;
        pc_in    = {$urandom, $urandom};
      end
      out_ready = (c >= 100 && c < 120) ? 1'b1 : ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      if (c == 300) begin
        nrst = 1'b0;
        #1;
        chk("async reset out_valid", if32.out_valid, 0);
        chk("async reset occupancy", if64.occupancy, 0);
        #1;
        nrst = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
